// File: rtl/rom_loader.sv
// ============================================================================
//  Module      : rom_loader
//  Description : Boot-time program loader. Consumes a byte stream of the form
//                LEN_LO, LEN_HI, 4*N data bytes (little-endian words), XOR
//                checksum byte, and writes the words into instruction memory.
//                The core is held in reset until the whole image has been
//                written and the checksum matches.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                rx_valid_i/rx_data_i/rx_ready_o - byte stream handshake
//                mem_we_o/mem_addr_o/mem_wdata_o - instruction memory write
//                cpu_rst_o           - core reset, released on good load
//                load_done_o         - sticky, image loaded and verified
//                load_err_o          - sticky, length overflow or bad checksum
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_loader #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    output logic                  rx_ready_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic                  cpu_rst_o,
    output logic                  load_done_o,
    output logic                  load_err_o
);

    localparam logic [2:0] c_LEN0 = 3'd0;
    localparam logic [2:0] c_LEN1 = 3'd1;
    localparam logic [2:0] c_DATA = 3'd2;
    localparam logic [2:0] c_CSUM = 3'd3;
    localparam logic [2:0] c_DONE = 3'd4;
    localparam logic [2:0] c_ERR  = 3'd5;

    // Largest legal word count: the full memory capacity.
    localparam logic [16:0] c_CAP = 17'(1) << ADDR_WIDTH;

    logic [2:0]            r_state;
    logic [15:0]           r_len;
    // One extra bit so a full-capacity image does not wrap to zero.
    logic [ADDR_WIDTH:0]   r_wcnt;
    logic [1:0]            r_bidx;
    // Bytes 0..2 of the current word; byte 0 ends up in bits 7:0.
    logic [23:0]           r_asm;
    logic [7:0]            r_xor;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_cpu_rst;
    logic                  r_done;
    logic                  r_err;

    logic                  w_ready;
    logic                  w_xfer;
    logic [15:0]           w_len_new;
    logic [ADDR_WIDTH:0]   w_wcnt_inc;
    logic                  w_last_word;

    assign w_ready     = (r_state == c_LEN0) || (r_state == c_LEN1) ||
                         (r_state == c_DATA) || (r_state == c_CSUM);
    assign w_xfer      = rx_valid_i && w_ready;
    assign w_len_new   = {rx_data_i, r_len[7:0]};
    assign w_wcnt_inc  = r_wcnt + {{ADDR_WIDTH{1'b0}}, 1'b1};
    // Word being completed is word N-1 when the incremented count reaches N.
    assign w_last_word = (17'(w_wcnt_inc) == {1'b0, r_len});

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_LEN0;
            r_len     <= '0;
            r_wcnt    <= '0;
            r_bidx    <= '0;
            r_asm     <= '0;
            r_xor     <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_cpu_rst <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Write strobe is a single-cycle pulse.
            r_we <= 1'b0;
            if (w_xfer) begin
                case (r_state)
                    c_LEN0: begin
                        r_len[7:0] <= rx_data_i;
                        r_xor      <= r_xor ^ rx_data_i;
                        r_state    <= c_LEN1;
                    end
                    c_LEN1: begin
                        r_len[15:8] <= rx_data_i;
                        r_xor       <= r_xor ^ rx_data_i;
                        if ({1'b0, w_len_new} > c_CAP) begin
                            r_state <= c_ERR;
                            r_err   <= 1'b1;
                        end else if (w_len_new == 16'd0) begin
                            r_state <= c_CSUM;
                        end else begin
                            r_state <= c_DATA;
                        end
                    end
                    c_DATA: begin
                        r_xor  <= r_xor ^ rx_data_i;
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_wcnt[ADDR_WIDTH-1:0];
                            r_wdata <= {rx_data_i, r_asm};
                            r_wcnt  <= w_wcnt_inc;
                            if (w_last_word) begin
                                r_state <= c_CSUM;
                            end
                        end else begin
                            r_asm <= {rx_data_i, r_asm[23:8]};
                        end
                    end
                    c_CSUM: begin
                        if (rx_data_i == r_xor) begin
                            r_state   <= c_DONE;
                            r_cpu_rst <= 1'b0;
                            r_done    <= 1'b1;
                        end else begin
                            r_state <= c_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE/ERR never accept bytes; nothing to do.
                    end
                endcase
            end
        end
    end

    assign rx_ready_o  = w_ready;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign cpu_rst_o   = r_cpu_rst;
    assign load_done_o = r_done;
    assign load_err_o  = r_err;

endmodule

`default_nettype wire
